// File: rtl/glitch_pulse_gen_if.sv
// Bus between the resetter/command side and the short-glitch timing stage.
// The state_dbg field exposes the FSM state so that checkers can bind to it.
interface glitch_pulse_gen_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 wide_glitch;
  logic [WIDTH-1:0]     offset;
  logic [WIDTH-1:0]     duration;
  logic                 power_select;
  logic                 power_ctrl;
  logic                 rx_hold;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] glitch_count;
  logic [2:0]           state_dbg;

  modport master (
    output wide_glitch, offset, duration,
    input  power_select, power_ctrl, rx_hold, busy, done, glitch_count, state_dbg
  );

  modport slave (
    input  wide_glitch, offset, duration,
    output power_select, power_ctrl, rx_hold, busy, done, glitch_count, state_dbg
  );
endinterface

// File: rtl/glitch_pulse_gen.sv
// Post-wide-glitch timer: after wide_glitch falls, wait offset cycles, drive a
// duration-cycle short glitch, then gate the host UART rx for a hold-off period.
module glitch_pulse_gen #(
    parameter int WIDTH          = 32,
    parameter int HOLDOFF_CYCLES = 100000,
    parameter int CNT_WIDTH      = 16
) (
    input logic clk,
    input logic reset,
    glitch_pulse_gen_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_OFFSET = 3'd2;
    localparam logic [2:0] S_PULSE  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [WIDTH-1:0] HOLD_LOAD = WIDTH'(HOLDOFF_CYCLES);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [2:0]           state;
    logic                 wg_d;
    logic [WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]     dur_sh;
    logic                 power_select;
    logic                 rx_hold;
    logic                 done;
    logic [CNT_WIDTH-1:0] glitch_count;
    logic                 rise;
    logic                 fall;

    // wide_glitch is a level strobe with no back-pressure: its edges are
    // detected against wg_d, and the stage never stalls the resetter.
    assign rise = !wg_d && bus.wide_glitch;
    assign fall = wg_d && !bus.wide_glitch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wg_d         <= 1'b0;
            cnt          <= '0;
            dur_sh       <= '0;
            power_select <= 1'b0;
            rx_hold      <= 1'b0;
            done         <= 1'b0;
            glitch_count <= '0;
        end else begin
            wg_d <= bus.wide_glitch;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state   <= S_ARMED;
                        rx_hold <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (fall) begin
                        state  <= S_OFFSET;
                        cnt    <= bus.offset;
                        dur_sh <= bus.duration;
                    end
                end
                S_OFFSET, S_PULSE, S_HOLD: begin
                    // A new wide glitch restarts the cycle from any active state.
                    if (rise) begin
                        state        <= S_ARMED;
                        power_select <= 1'b0;
                    end else if (state == S_OFFSET) begin
                        if (cnt != '0) begin
                            cnt <= cnt - ONE;
                        end else if (dur_sh != '0) begin
                            state        <= S_PULSE;
                            power_select <= 1'b1;
                            cnt          <= dur_sh;
                        end else begin
                            state <= S_HOLD;
                            cnt   <= HOLD_LOAD;
                        end
                    end else if (state == S_PULSE) begin
                        if (cnt == ONE) begin
                            state        <= S_HOLD;
                            power_select <= 1'b0;
                            cnt          <= HOLD_LOAD;
                            if (glitch_count != '1)
                                glitch_count <= glitch_count + CNT_WIDTH'(1);
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end else begin
                        if (cnt == '0) begin
                            state   <= S_IDLE;
                            rx_hold <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.power_select = power_select;
    assign bus.power_ctrl   = bus.wide_glitch | power_select;
    assign bus.rx_hold      = rx_hold;
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = done;
    assign bus.glitch_count = glitch_count;
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Bench for glitch_pulse_gen: per-edge expected outputs are derived from the
// offset/duration/hold-off timing rules and queued before each sequence.
module tb_glitch_pulse_gen;
  localparam int W  = 32;
  localparam int CW = 2;
  localparam int H  = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   exp_cnt;
  logic [3:0] exp_q[$];

  glitch_pulse_gen_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  glitch_pulse_gen #(.WIDTH(W), .HOLDOFF_CYCLES(H), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rise the wide glitch, hold it hi cycles, then drop it just before edge E
  task automatic start_glitch(input int o, input int d, input int hi);
    bus.offset      = W'(o);
    bus.duration    = W'(d);
    bus.wide_glitch = 1'b1;
    #1;
    n_tests++;
    if (bus.power_ctrl !== 1'b1) begin
      n_fail++;
      $display("FAIL power_ctrl_follow_rise got %b exp 1", bus.power_ctrl);
    end
    step();
    n_tests++;
    if ({bus.rx_hold, bus.busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL rise_armed rx_hold/busy got %b exp 11", {bus.rx_hold, bus.busy});
    end
    repeat (hi - 1) step();
    bus.wide_glitch = 1'b0;
    #1;
    n_tests++;
    if (bus.power_ctrl !== 1'b0) begin
      n_fail++;
      $display("FAIL power_ctrl_follow_fall got %b exp 0", bus.power_ctrl);
    end
  endtask

  // edge E and every edge after it until one cycle past done
  // snap: 0 inputs untouched, 1 offset->50 after E+1, 2 random inputs after E+1
  task automatic run_after_fall(input int o, input int d, input int snap);
    int t;
    logic [3:0] exp;
    logic [3:0] got;
    t = ((d > 0) ? (o + d + 1) : (o + 1)) + H + 1;
    exp_q.delete();
    for (int k = 0; k <= t + 1; k++)
      exp_q.push_back({k < t, (d > 0) && (k >= o + 1) && (k <= o + d), k < t, k == t});
    for (int k = 0; k <= t + 1; k++) begin
      step();
      exp = exp_q.pop_front();
      got = {bus.busy, bus.power_select, bus.rx_hold, bus.done};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL seq o=%0d d=%0d edge E+%0d busy/ps/rx/done got %b exp %b",
                 o, d, k, got, exp);
      end
      n_tests++;
      if (bus.power_ctrl !== exp[2]) begin
        n_fail++;
        $display("FAIL power_ctrl o=%0d d=%0d edge E+%0d got %b exp %b",
                 o, d, k, bus.power_ctrl, exp[2]);
      end
      if (k == 1 && snap == 1) bus.offset = W'(50);
      if (k == 1 && snap == 2) begin
        bus.offset   = W'($urandom_range(0, 60));
        bus.duration = W'($urandom_range(0, 60));
      end
    end
    if (d > 0 && exp_cnt != 3) exp_cnt++;
    n_tests++;
    if (bus.glitch_count !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL glitch_count o=%0d d=%0d got %0d exp %0d", o, d, bus.glitch_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.wide_glitch = 1'b0;
    bus.offset      = '0;
    bus.duration    = '0;
    repeat (3) step();
    exp_cnt = 0;
    n_tests++;
    if ({bus.power_select, bus.power_ctrl, bus.rx_hold, bus.busy, bus.done} !== 5'b0 ||
        bus.glitch_count !== '0) begin
      n_fail++;
      $display("FAIL reset_values ps/pc/rx/busy/done got %b cnt %0d exp 00000 cnt 0",
               {bus.power_select, bus.power_ctrl, bus.rx_hold, bus.busy, bus.done},
               bus.glitch_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    start_glitch(3, 5, 10);
    run_after_fall(3, 5, 0);
  endtask

  task automatic test_min_values();
    start_glitch(0, 1, 2);
    run_after_fall(0, 1, 0);
  endtask

  task automatic test_zero_duration();
    start_glitch(2, 0, 3);
    run_after_fall(2, 0, 0);
  endtask

  task automatic test_abort();
    start_glitch(2, 10, 3);
    for (int k = 0; k <= 5; k++) begin
      step();
      n_tests++;
      if (bus.power_select !== (k >= 3)) begin
        n_fail++;
        $display("FAIL abort_pre edge E+%0d ps got %b exp %b", k, bus.power_select, k >= 3);
      end
    end
    bus.wide_glitch = 1'b1;
    step();
    n_tests++;
    if ({bus.power_select, bus.rx_hold, bus.done, bus.busy} !== 4'b0101 ||
        bus.state_dbg !== 3'd1 || bus.glitch_count !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL abort ps/rx/done/busy got %b state %0d cnt %0d exp 0101 state 1 cnt %0d",
               {bus.power_select, bus.rx_hold, bus.done, bus.busy}, bus.state_dbg,
               bus.glitch_count, exp_cnt);
    end
    step();
    n_tests++;
    if (bus.done !== 1'b0 || bus.power_select !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold done/ps got %b exp 00", {bus.done, bus.power_select});
    end
    bus.wide_glitch = 1'b0;
    #1;
    run_after_fall(2, 10, 0);
  endtask

  task automatic test_snapshot();
    start_glitch(3, 5, 4);
    run_after_fall(3, 5, 1);
    bus.offset = W'(3);
  endtask

  task automatic test_reset_mid_pulse();
    start_glitch(3, 5, 2);
    repeat (6) step();
    n_tests++;
    if (bus.power_select !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_pulse ps got %b exp 1", bus.power_select);
    end
    reset = 1'b1;
    step();
    exp_cnt = 0;
    n_tests++;
    if ({bus.power_select, bus.power_ctrl, bus.rx_hold, bus.busy, bus.done} !== 5'b0 ||
        bus.glitch_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse ps/pc/rx/busy/done got %b cnt %0d exp 00000 cnt 0",
               {bus.power_select, bus.power_ctrl, bus.rx_hold, bus.busy, bus.done},
               bus.glitch_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      start_glitch(1, 1, 2);
      run_after_fall(1, 1, 0);
    end
    n_tests++;
    if (bus.glitch_count !== 2'd3) begin
      n_fail++;
      $display("FAIL saturation got %0d exp 3", bus.glitch_count);
    end
  endtask

  task automatic test_random();
    int o;
    int d;
    for (int i = 0; i < 8; i++) begin
      o = int'($urandom_range(0, 6));
      d = int'($urandom_range(0, 6));
      start_glitch(o, d, int'($urandom_range(1, 5)));
      run_after_fall(o, d, 2);
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    test_reset();
    test_nominal();
    test_min_values();
    test_zero_duration();
    test_abort();
    test_snapshot();
    test_reset_mid_pulse();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/glitch_pulse_gen.md
# glitch_pulse_gen

Post-wide-glitch timing stage: watches the `wide_glitch` strobe from the resetter, and after its falling edge it waits a programmed offset and then drives a programmed-width short power glitch. It then holds the host UART receive path gated for a settling period before re-arming. It sits between the resetter/command processor and the `power_ctrl` pin. It replaces the separate offset/duration counters and the inline handshake-hold logic with one FSM and a snapshot of its parameters.

## Interface
- `WIDTH`, 32, width of offset/duration values and counters
- `HOLDOFF_CYCLES`, 100000, post-glitch UART gating period in `clk` cycles (≥1)
- `CNT_WIDTH`, 16, width of completed-glitch counter
- `clk` in 1: system clock (PLL output)
- `reset` in 1: synchronous, active-high reset
- `wide_glitch` in 1: wide power-cut strobe from resetter
- `offset` in WIDTH: cycles from wide-glitch fall to short-glitch start
- `duration` in WIDTH: short-glitch width in cycles
- `power_select` out 1: registered short-glitch output
- `power_ctrl` out 1: `wide_glitch | power_select` (combinational)
- `rx_hold` out 1: registered; 1 = force host UART rx idle-high
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse on return to IDLE after hold-off
- `glitch_count` out CNT_WIDTH: completed short glitches, saturating

## Operation
- Reset values:
  - `power_select`, `rx_hold`, `done`, `busy` = 0; `glitch_count` = 0.
  - State = IDLE; internal `wg_d` = 0.
- `wg_d` registers `wide_glitch` every cycle.
  - rise = `!wg_d & wide_glitch`
  - fall = `wg_d & !wide_glitch`
- States: IDLE, ARMED, OFFSET, PULSE, HOLD.
- IDLE: on rise go to ARMED and set `rx_hold` = 1.
- ARMED: on fall go to OFFSET. At that same edge:
  - latch `offset` and `duration` into shadow registers;
  - load `cnt` = `offset`.
  - Later changes to the `offset`/`duration` inputs have no effect until the next fall.
- OFFSET:
  - If `cnt` = 0 and shadow duration ≠ 0: go to PULSE, set `power_select` = 1, load `cnt` = duration.
  - If `cnt` = 0 and shadow duration = 0: go to HOLD with `cnt` = `HOLDOFF_CYCLES`. No pulse is issued and the count is unchanged.
  - Otherwise decrement `cnt`.
- PULSE:
  - If `cnt` = 1: clear `power_select`, increment `glitch_count` (saturating at all-ones), go to HOLD with `cnt` = `HOLDOFF_CYCLES`.
  - Otherwise decrement `cnt`.
- HOLD:
  - If `cnt` = 0: go to IDLE, clear `rx_hold`, pulse `done` = 1 for one cycle.
  - Otherwise decrement `cnt`.
- Abort (new glitch cycle) from OFFSET, PULSE or HOLD: a rise at any edge has priority over all other transitions.
  - Go to ARMED; `power_select` = 0 at that edge; `rx_hold` stays 1.
  - `glitch_count` is unchanged; `done` is not pulsed.
- A fall in IDLE (no preceding rise seen) is ignored.
- Reset mid-operation forces all reset values at the next edge, including a synchronous drop of `power_select`.

## Timing
- Let E = the edge at which the fall is sampled, O = offset, D = duration, H = `HOLDOFF_CYCLES`.
- `power_select` goes high at edge E+O+1 and low at edge E+O+D+1, giving exactly D cycles high.
- HOLD is entered at edge E+O+D+1 (or E+O+1 when D = 0).
- `rx_hold` falls and `done` pulses at HOLD entry + H + 1.
- `rx_hold` goes high at the edge after `wide_glitch` rises (1-cycle latency from `wg_d`).
- `power_ctrl` has no added latency from `wide_glitch`.
- O = 0 is legal: the pulse starts at E+1.
- Full-scale O and D (2^WIDTH−1) are legal. Counters never wrap because every decrement is guarded.
- `glitch_count` saturates at 2^CNT_WIDTH−1.

## Test plan
All scenarios use `HOLDOFF_CYCLES` = 4.
- **Nominal:** O=3, D=5; `wide_glitch` high 10 cycles then low, fall sampled at E.
  - `power_select` high exactly for edges E+4..E+8 and low at E+9.
  - `rx_hold` falls and `done` pulses at E+14; `glitch_count` = 1.
- **Minimum values:** O=0, D=1. Exactly one `power_select` cycle, starting at E+1; `done` at E+7.
- **Zero duration:** O=2, D=0. `power_select` never asserts; `done` at E+8; `glitch_count` unchanged.
- **Abort:** O=2, D=10; `wide_glitch` re-rises at E+6.
  - `power_select` is 0 from E+6; state ARMED; `rx_hold` stays 1; no `done`; count unchanged.
  - After the next fall the full sequence runs normally.
- **Snapshot and reset:**
  - Change `offset` 3→50 at E+1: the pulse still starts at E+4.
  - Assert `reset` during PULSE: at the next edge all outputs are 0 and `busy` = 0.
- **Saturation:** with `CNT_WIDTH` = 2, run 5 glitches. `glitch_count` sticks at 3.
